// File: rtl/stream_sel_mux.sv
// -----------------------------------------------------------------------------
// stream_sel_mux
//   N-channel, WIDTH-bit stream selector with valid/ready handshake and a
//   single registered output stage. The granted channel is picked either by
//   an explicit index (RR_MODE=0) or by round-robin over the valid channels
//   (RR_MODE=1). One beat per cycle is sustained: the output register can be
//   drained and refilled on the same edge.
//
// Ports
//   clk       : clock, all state on the rising edge
//   reset     : synchronous, active-high reset
//   sel       : channel index, only used when RR_MODE=0
//   in_valid  : per-channel valid
//   in_data   : packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_ready  : per-channel ready, combinational, one-hot or zero
//   out_valid : output register holds a beat
//   out_data  : output beat, zero whenever out_valid=0
//   out_ch    : channel id of the current output beat
//   out_ready : sink accepts the beat when out_valid & out_ready
//   err_sel   : registered one-cycle flag for an out-of-range sel while any
//               channel is valid (RR_MODE=0 only)
// -----------------------------------------------------------------------------
module stream_sel_mux #(
    parameter int NUM_CH  = 6,
    parameter int WIDTH   = 4,
    parameter int SEL_W   = $clog2(NUM_CH),
    parameter int RR_MODE = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    input  logic                    out_ready,
    output logic                    err_sel
);

    // One extra bit so sel can be compared against NUM_CH without wrapping.
    localparam logic [SEL_W:0]   NUM_CH_W  = (SEL_W+1)'(NUM_CH);
    localparam logic [SEL_W-1:0] LAST_CH_W = SEL_W'(NUM_CH - 1);

    logic                    out_valid_r;
    logic [WIDTH-1:0]        out_data_r;
    logic [SEL_W-1:0]        out_ch_r;
    logic                    err_sel_r;
    logic [SEL_W-1:0]        rr_last_r;

    logic                    can_accept_s;
    logic                    grant_valid_s;
    logic [SEL_W-1:0]        grant_s;
    logic [NUM_CH-1:0]       in_ready_s;
    logic                    xfer_s;
    logic [WIDTH-1:0]        grant_data_s;
    logic                    err_next_s;

    // The output register can take a new beat when empty or being drained.
    assign can_accept_s = ~out_valid_r | out_ready;

    // Grant selection: explicit index, or round-robin scan starting after rr_last.
    always_comb begin : grant_comb
        int idx;
        idx           = 0;
        grant_valid_s = 1'b0;
        grant_s       = '0;
        if (RR_MODE == 0) begin
            if ({1'b0, sel} < NUM_CH_W) begin
                grant_valid_s = 1'b1;
                grant_s       = sel;
            end else begin
                grant_valid_s = 1'b0;
                grant_s       = '0;
            end
        end else begin
            // Scan rr_last+1 .. rr_last+NUM_CH with wrap; first valid wins.
            for (int k = 1; k <= NUM_CH; k++) begin
                idx = int'(rr_last_r) + k;
                if (idx >= NUM_CH) begin
                    idx = idx - NUM_CH;
                end else begin
                    idx = idx;
                end
                if (!grant_valid_s && in_valid[idx]) begin
                    grant_valid_s = 1'b1;
                    grant_s       = SEL_W'(idx);
                end else begin
                    grant_valid_s = grant_valid_s;
                    grant_s       = grant_s;
                end
            end
        end
    end

    // Ready goes to the granted channel only, independent of its valid.
    always_comb begin
        in_ready_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            in_ready_s[i] = grant_valid_s & can_accept_s & (grant_s == SEL_W'(i));
        end
    end

    // Data of the granted channel.
    always_comb begin
        grant_data_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_s == SEL_W'(i)) begin
                grant_data_s = in_data[i*WIDTH +: WIDTH];
            end else begin
                grant_data_s = grant_data_s;
            end
        end
    end

    assign xfer_s     = |(in_valid & in_ready_s);
    assign err_next_s = (RR_MODE == 0) & ({1'b0, sel} >= NUM_CH_W) & (|in_valid);

    // Output register, round-robin pointer and error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_ch_r    <= '0;
            err_sel_r   <= 1'b0;
            rr_last_r   <= LAST_CH_W;
        end else begin
            err_sel_r <= err_next_s;
            if (xfer_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= grant_data_s;
                out_ch_r    <= grant_s;
                if (RR_MODE != 0) begin
                    rr_last_r <= grant_s;
                end else begin
                    rr_last_r <= rr_last_r;
                end
            end else if (out_ready) begin
                // Beat drained with nothing to replace it: go empty, data reads 0.
                out_valid_r <= 1'b0;
                out_data_r  <= '0;
            end else begin
                out_valid_r <= out_valid_r;
                out_data_r  <= out_data_r;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_ch    = out_ch_r;
    assign err_sel   = err_sel_r;

endmodule

// File: tb/tb_stream_sel_mux.sv
// -----------------------------------------------------------------------------
// tb_stream_sel_mux
//   Directed bench for stream_sel_mux. Three instances share clock and reset:
//   dut (6x4, explicit select), rr (6x4, round-robin) and n3 (3x8, explicit
//   select). Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_stream_sel_mux;

    logic        clk;
    logic        reset;

    // 6x4 explicit-select instance
    logic [2:0]  d_sel;
    logic [5:0]  d_valid;
    logic [23:0] d_data;
    logic [5:0]  d_ready;
    logic        d_ovalid;
    logic [3:0]  d_odata;
    logic [2:0]  d_och;
    logic        d_oready;
    logic        d_err;

    // 6x4 round-robin instance
    logic [2:0]  r_sel;
    logic [5:0]  r_valid;
    logic [23:0] r_data;
    logic [5:0]  r_ready;
    logic        r_ovalid;
    logic [3:0]  r_odata;
    logic [2:0]  r_och;
    logic        r_oready;
    logic        r_err;

    // 3x8 explicit-select instance
    logic [1:0]  n_sel;
    logic [2:0]  n_valid;
    logic [23:0] n_data;
    logic [2:0]  n_ready;
    logic        n_ovalid;
    logic [7:0]  n_odata;
    logic [1:0]  n_och;
    logic        n_oready;
    logic        n_err;

    int checks = 0;
    int errors = 0;

    stream_sel_mux #(.NUM_CH(6), .WIDTH(4), .RR_MODE(0)) dut (
        .clk(clk), .reset(reset), .sel(d_sel), .in_valid(d_valid), .in_data(d_data),
        .in_ready(d_ready), .out_valid(d_ovalid), .out_data(d_odata), .out_ch(d_och),
        .out_ready(d_oready), .err_sel(d_err)
    );

    stream_sel_mux #(.NUM_CH(6), .WIDTH(4), .RR_MODE(1)) rr (
        .clk(clk), .reset(reset), .sel(r_sel), .in_valid(r_valid), .in_data(r_data),
        .in_ready(r_ready), .out_valid(r_ovalid), .out_data(r_odata), .out_ch(r_och),
        .out_ready(r_oready), .err_sel(r_err)
    );

    stream_sel_mux #(.NUM_CH(3), .WIDTH(8), .RR_MODE(0)) n3 (
        .clk(clk), .reset(reset), .sel(n_sel), .in_valid(n_valid), .in_data(n_data),
        .in_ready(n_ready), .out_valid(n_ovalid), .out_data(n_odata), .out_ch(n_och),
        .out_ready(n_oready), .err_sel(n_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int exp_ch [11];
        exp_ch = '{0, 1, 2, 3, 4, 5, 0, 2, 5, 2, 5};

        reset = 1'b1;
        d_sel = 3'd0; d_valid = 6'd0; d_data = 24'd0; d_oready = 1'b0;
        r_sel = 3'd0; r_valid = 6'd0; r_data = 24'h654321; r_oready = 1'b1;
        n_sel = 2'd0; n_valid = 3'd0; n_data = 24'd0; n_oready = 1'b1;
        step();
        reset = 1'b0;

        // Reset state
        check("rst_ovalid", 32'(d_ovalid), 32'd0);
        check("rst_odata",  32'(d_odata),  32'd0);
        check("rst_och",    32'(d_och),    32'd0);
        check("rst_err",    32'(d_err),    32'd0);
        check("rst_rr_ovalid", 32'(r_ovalid), 32'd0);

        // 1) explicit select of channel 3
        d_sel = 3'd3; d_valid = 6'b001000; d_data = 24'h00A000; d_oready = 1'b1;
        #1;
        check("t1_in_ready", 32'(d_ready), 32'h08);
        step();
        check("t1_ovalid", 32'(d_ovalid), 32'd1);
        check("t1_odata",  32'(d_odata),  32'hA);
        check("t1_och",    32'(d_och),    32'd3);
        check("t1_err",    32'(d_err),    32'd0);

        // 2) back-pressure holds the beat, then the new beat follows
        d_oready = 1'b0; d_data = 24'h00B000;
        #1;
        check("t2_in_ready_bp", 32'(d_ready), 32'h00);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_hold_data",  32'(d_odata),  32'hA);
            check("t2_hold_valid", 32'(d_ovalid), 32'd1);
        end
        d_oready = 1'b1;
        #1;
        check("t2_in_ready_rel", 32'(d_ready), 32'h08);
        step();
        check("t2_new_data", 32'(d_odata), 32'hB);
        d_valid = 6'd0;
        step();
        check("t2_drain_valid", 32'(d_ovalid), 32'd0);
        check("t2_drain_data",  32'(d_odata),  32'd0);

        // 3) out-of-range select
        d_sel = 3'd6; d_valid = 6'h3F;
        #1;
        check("t3_in_ready6", 32'(d_ready), 32'h00);
        step();
        check("t3_err6",    32'(d_err),    32'd1);
        check("t3_ovalid6", 32'(d_ovalid), 32'd0);
        check("t3_odata6",  32'(d_odata),  32'd0);
        d_sel = 3'd7;
        #1;
        check("t3_in_ready7", 32'(d_ready), 32'h00);
        step();
        check("t3_err7", 32'(d_err), 32'd1);
        d_valid = 6'd0;
        step();
        check("t3_err7_idle", 32'(d_err), 32'd0);

        // 5) reset while FULL, back-pressured and flagging an error;
        //    round-robin instance advanced first so reset must rewind it.
        d_sel = 3'd1; d_valid = 6'b000010; d_data = 24'h000050; d_oready = 1'b0;
        r_valid = 6'h3F;
        step();
        check("t5_fill_data", 32'(d_odata), 32'h5);
        check("t5_rr_pre0",   32'(r_och),   32'd0);
        d_sel = 3'd6; d_valid = 6'h3F;
        step();
        check("t5_hold_data", 32'(d_odata), 32'h5);
        check("t5_pre_err",   32'(d_err),   32'd1);
        check("t5_rr_pre1",   32'(r_och),   32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        d_valid = 6'd0; d_sel = 3'd0;
        check("t5_ovalid", 32'(d_ovalid), 32'd0);
        check("t5_odata",  32'(d_odata),  32'd0);
        check("t5_err",    32'(d_err),    32'd0);
        check("t5_och",    32'(d_och),    32'd0);
        check("t5_rr_ovalid", 32'(r_ovalid), 32'd0);

        // 4) round-robin order, restarting at channel 0 after reset
        #1;
        check("t4_rr_in_ready", 32'(r_ready), 32'h01);
        for (int i = 0; i < 11; i++) begin
            if (i == 7) begin
                r_valid = 6'b100100;
            end
            step();
            check("t4_rr_och",   32'(r_och),   32'(exp_ch[i]));
            check("t4_rr_odata", 32'(r_odata), 32'(exp_ch[i] + 1));
            check("t4_rr_err",   32'(r_err),   32'd0);
        end

        // 6) three-channel, 8-bit instance
        n_sel = 2'd2; n_valid = 3'b111; n_data = 24'h5C0000;
        step();
        check("t6_odata",  32'(n_odata),  32'h5C);
        check("t6_och",    32'(n_och),    32'd2);
        check("t6_ovalid", 32'(n_ovalid), 32'd1);
        n_sel = 2'd3;
        #1;
        check("t6_in_ready3", 32'(n_ready), 32'h0);
        step();
        check("t6_err3",    32'(n_err),    32'd1);
        check("t6_ovalid3", 32'(n_ovalid), 32'd0);
        check("t6_odata3",  32'(n_odata),  32'd0);
        n_valid = 3'd0;
        step();
        check("t6_err_idle", 32'(n_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
